// File: rtl/ob.sv
// rtl/ob.sv - crossbar output-port buffer: FWFT packet FIFO with delivery and drop counters
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   i      incoming packet; bit PKTW set means a packet is present
//   full   no free entry (combinational from registered occupancy)
//   o      head-of-queue packet, zero while the queue is empty
//   ov     o holds a valid packet
//   ordy   downstream accepts o this cycle
//   cnt    occupancy, 0..DEPTH
//   txcnt  packets delivered downstream, modulo 256
//   drop   packets discarded on overflow, saturating at 255
module ob #(
    parameter int PKTW  = 15,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PKTW:0]              i,
    output logic                       full,
    output logic [PKTW:0]              o,
    output logic                       ov,
    input  logic                       ordy,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic [7:0]                 txcnt,
    output logic [7:0]                 drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [PKTW:0]   mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            push;
    logic            pop;
    logic            overflow;

    assign ov       = (cnt != '0);
    assign full     = (cnt == CNT_FULL);
    assign pop      = ov & ordy;
    // A full queue still accepts a packet when the head leaves in the same cycle.
    assign push     = i[PKTW] & (~full | pop);
    assign overflow = i[PKTW] & full & ~pop;
    assign o        = ov ? mem[rp] : '0;

    // Storage is never cleared; o is masked while the queue is empty so stale
    // entries cannot leak out after reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wp] <= i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            txcnt <= '0;
            drop  <= '0;
        end else begin
            // Pointer widths match log2(DEPTH), so natural wrap gives modulo DEPTH.
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp    <= rp + 1'b1;
                txcnt <= txcnt + 8'd1;
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt <= cnt - CNT_ONE;
            end
            if (overflow && drop != 8'hFF) begin
                drop <= drop + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ob.sv
// tb/tb_ob.sv - scoreboard testbench for ob
module tb_ob;

    localparam int PKTW  = 15;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] i;
    logic        full;
    logic [15:0] o;
    logic        ov;
    logic        ordy;
    logic [2:0]  cnt;
    logic [7:0]  txcnt;
    logic [7:0]  drop;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    int          mcnt = 0;

    ob #(.PKTW(PKTW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .i     (i),
        .full  (full),
        .o     (o),
        .ov    (ov),
        .ordy  (ordy),
        .cnt   (cnt),
        .txcnt (txcnt),
        .drop  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on the falling edge, a pending delivery is compared to the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            if (ov && ordy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got %0h expected none", o);
                end else begin
                    chk("delivery", {16'h0, o}, {16'h0, sb.pop_front()});
                end
            end else if (!ov) begin
                chk("idle_o_zero", {16'h0, o}, 32'h0);
            end
        end
    end

    // One clock cycle of stimulus; the expected queue contents follow a simple occupancy model.
    task automatic cycle(input logic [15:0] iv, input logic rv);
        bit p_pop;
        bit p_push;
        i    = iv;
        ordy = rv;
        p_pop  = (mcnt != 0) && rv;
        p_push = iv[15] && (mcnt < DEPTH || p_pop);
        if (p_push) sb.push_back(iv);
        mcnt = mcnt + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_sync();
        rst  = 1'b0;
        i    = '0;
        ordy = 1'b0;
        sb.delete();
        mcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        i    = '0;
        ordy = 1'b0;
        #2;
        chk("rst_cnt",   {29'h0, cnt}, 32'd0);
        chk("rst_ov",    {31'h0, ov}, 32'd0);
        reset_sync();
        chk("rst_full",  {31'h0, full}, 32'd0);
        chk("rst_o",     {16'h0, o}, 32'h0);
        chk("rst_txcnt", {24'h0, txcnt}, 32'd0);
        chk("rst_drop",  {24'h0, drop}, 32'd0);

        // Single push becomes visible the next cycle.
        cycle(16'h8001, 1'b0);
        chk("first_ov",   {31'h0, ov}, 32'd1);
        chk("first_o",    {16'h0, o}, 32'h8001);
        chk("first_cnt",  {29'h0, cnt}, 32'd1);
        chk("first_full", {31'h0, full}, 32'd0);

        // Fill, then overflow.
        for (int k = 2; k <= 4; k++) cycle(16'h8000 | 16'(k), 1'b0);
        chk("fill_cnt",  {29'h0, cnt}, 32'd4);
        chk("fill_full", {31'h0, full}, 32'd1);
        cycle(16'h8005, 1'b0);
        chk("ovf_drop",  {24'h0, drop}, 32'd1);
        chk("ovf_cnt",   {29'h0, cnt}, 32'd4);
        chk("stable_o",  {16'h0, o}, 32'h8001);

        // Push and pop together while full.
        cycle(16'h80AA, 1'b1);
        chk("fullpp_cnt",  {29'h0, cnt}, 32'd4);
        chk("fullpp_drop", {24'h0, drop}, 32'd1);
        chk("fullpp_o",    {16'h0, o}, 32'h8002);

        repeat (4) cycle(16'h0000, 1'b1);
        chk("drain_ov",    {31'h0, ov}, 32'd0);
        chk("drain_cnt",   {29'h0, cnt}, 32'd0);
        chk("drain_txcnt", {24'h0, txcnt}, 32'd5);

        // ordy on an empty queue does nothing.
        cycle(16'h0000, 1'b1);
        chk("empty_ordy_txcnt", {24'h0, txcnt}, 32'd5);

        // Idle slots are never written, whatever the payload bits hold.
        for (int k = 0; k < 10; k++) cycle(16'h7FFF, 1'(k & 1));
        chk("idle_cnt",  {29'h0, cnt}, 32'd0);
        chk("idle_ov",   {31'h0, ov}, 32'd0);
        chk("idle_drop", {24'h0, drop}, 32'd1);

        // Streaming 260 packets wraps txcnt.
        reset_sync();
        for (int k = 0; k < 260; k++) cycle(16'h8000 | 16'(k), 1'b1);
        chk("stream_cnt", {29'h0, cnt}, 32'd1);
        cycle(16'h0000, 1'b1);
        chk("stream_txcnt", {24'h0, txcnt}, 32'd4);

        // 300 overflow attempts saturate drop.
        for (int k = 0; k < 4; k++) cycle(16'h8100 | 16'(k), 1'b0);
        for (int k = 0; k < 300; k++) cycle(16'hC000 | 16'(k), 1'b0);
        chk("sat_drop", {24'h0, drop}, 32'd255);
        chk("sat_cnt",  {29'h0, cnt}, 32'd4);
        repeat (4) cycle(16'h0000, 1'b1);
        chk("sat_txcnt", {24'h0, txcnt}, 32'd8);

        // Asynchronous reset mid-cycle discards the queue.
        for (int k = 0; k < 3; k++) cycle(16'h8200 | 16'(k), 1'b0);
        chk("pre_rst_cnt", {29'h0, cnt}, 32'd3);
        #2;
        rst = 1'b0;
        sb.delete();
        mcnt = 0;
        #1;
        chk("async_ov",   {31'h0, ov}, 32'd0);
        chk("async_cnt",  {29'h0, cnt}, 32'd0);
        chk("async_o",    {16'h0, o}, 32'h0);
        chk("async_drop", {24'h0, drop}, 32'd0);
        #1;
        rst = 1'b1;
        cycle(16'h8042, 1'b0);
        chk("post_rst_o",   {16'h0, o}, 32'h8042);
        chk("post_rst_cnt", {29'h0, cnt}, 32'd1);
        cycle(16'h0000, 1'b1);
        repeat (2) cycle(16'h0000, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
